// File: rtl/fifo_pkg.sv
// Shared FIFO types and default geometry.
// Used by the single-clock FIFO and the CDC FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  localparam int FIFO_DW = 4;
  localparam int FIFO_AW = 4;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port,
// registered read (STD) or combinational read (FWFT).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int         DW   = FIFO_DW,
  parameter int         AW   = FIFO_AW,
  parameter fifo_mode_e MODE = FIFO_STD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata <= '0;
      end else if (re) begin
        rdata <= mem[raddr];
      end
    end
  end else begin : g_fwft
    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with almost flags,
// occupancy, sticky errors, flush and optional FWFT.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DW,
  parameter int ADDR_WIDTH    = FIFO_AW,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  wafull,
  output logic                  overflow,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  raempty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam fifo_mode_e MODE =
    (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [ADDR_WIDTH:0] PTR_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_T =
    (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_T =
    (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  if (!(AEMPTY_THRESH < AFULL_THRESH &&
        AFULL_THRESH <= DEPTH)) begin : g_bad_cfg
    $error("sync_fifo_param: bad thresholds");
  end

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags decode from registered pointers only.
  assign count  = wptr - rptr;
  assign rempty = (wptr == rptr);
  assign wfull  =
    (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
    (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign wafull  = (count >= AF_T);
  assign raempty = (count <= AE_T);

  assign wr_ok = winc && !wfull && !flush;
  assign rd_ok = rinc && !rempty && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DW   (DATA_WIDTH),
    .AW   (ADDR_WIDTH),
    .MODE (MODE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // In FWFT mode an empty FIFO shows zero, not stale RAM.
  assign rdata =
    (MODE == FIFO_FWFT && rempty) ? '0 : mem_rdata;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a STD and an FWFT
// instance share stimulus and are checked against a queue model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [3:0] wdata = 4'h0;

  logic       s_wfull, s_wafull, s_ovf, s_rempty;
  logic       s_raempty, s_udf;
  logic [3:0] s_rdata;
  logic [4:0] s_count;

  logic       f_wfull, f_wafull, f_ovf, f_rempty;
  logic       f_raempty, f_udf;
  logic [3:0] f_rdata;
  logic [4:0] f_count;

  sync_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush),
    .winc(winc), .wdata(wdata), .wfull(s_wfull),
    .wafull(s_wafull), .overflow(s_ovf),
    .rinc(rinc), .rdata(s_rdata), .rempty(s_rempty),
    .raempty(s_raempty), .underflow(s_udf),
    .count(s_count)
  );

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush),
    .winc(winc), .wdata(wdata), .wfull(f_wfull),
    .wafull(f_wafull), .overflow(f_ovf),
    .rinc(rinc), .rdata(f_rdata), .rempty(f_rempty),
    .raempty(f_raempty), .underflow(f_udf),
    .count(f_count)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] mq[$];
  logic [3:0] exp_q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         mon_v;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_count", 32'(s_count), 0);
    chk("rst_rempty", 32'(s_rempty), 1);
    chk("rst_raempty", 32'(s_raempty), 1);
    chk("rst_wfull", 32'(s_wfull), 0);
    chk("rst_wafull", 32'(s_wafull), 0);
    chk("rst_ovf", 32'(s_ovf), 0);
    chk("rst_udf", 32'(s_udf), 0);
    chk("rst_rdata", 32'(s_rdata), 0);
    chk("rst_f_count", 32'(f_count), 0);
    chk("rst_f_rempty", 32'(f_rempty), 1);
    chk("rst_f_ovf", 32'(f_ovf), 0);
    chk("rst_f_rdata", 32'(f_rdata), 0);
  endtask

  task automatic chk_flags();
    int n;
    n = mq.size();
    chk("count", 32'(s_count), 32'(n));
    chk("wfull", 32'(s_wfull), 32'(n == DEPTH));
    chk("wafull", 32'(s_wafull), 32'(n >= 14));
    chk("rempty", 32'(s_rempty), 32'(n == 0));
    chk("raempty", 32'(s_raempty), 32'(n <= 2));
    chk("overflow", 32'(s_ovf), 32'(m_ovf));
    chk("underflow", 32'(s_udf), 32'(m_udf));
    chk("f_count", 32'(f_count), 32'(n));
    chk("f_rempty", 32'(f_rempty), 32'(n == 0));
    chk("f_overflow", 32'(f_ovf), 32'(m_ovf));
    chk("f_underflow", 32'(f_udf), 32'(m_udf));
    if (n > 0) chk("f_rdata", 32'(f_rdata), 32'(mq[0]));
    else chk("f_rdata_empty", 32'(f_rdata), 0);
  endtask

  // One clock: drive at negedge, update model at posedge.
  task automatic step(input bit w, input bit r,
                      input logic [3:0] d, input bit fl);
    int  n;
    bit  full, emp;
    @(negedge clk);
    winc = w; rinc = r; wdata = d; flush = fl;
    @(posedge clk);
    n = mq.size();
    full = (n == DEPTH);
    emp = (n == 0);
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && full) m_ovf = 1'b1;
      if (r && emp) m_udf = 1'b1;
      if (r && !emp) exp_q.push_back(mq.pop_front());
      if (w && !full) mq.push_back(d);
    end
    #1 chk_flags();
  endtask

  // Monitor: a STD read the DUT accepts must match the queue.
  initial begin
    forever begin
      @(posedge clk);
      mon_v = rinc && !s_rempty && !flush && rst;
      #1;
      if (mon_v) begin
        if (exp_q.size() == 0) begin
          chk("rdata_unexpected", 32'(s_rdata), 32'hdead);
        end else begin
          chk("rdata_std", 32'(s_rdata),
              32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    model_reset();
    #1 chk_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 1; i <= 16; i++) step(1, 0, 4'(i), 0);
    step(1, 0, 4'hA, 0);
    repeat (17) step(0, 1, 4'h0, 0);

    repeat (8) step(1, 0, 4'($urandom), 0);
    repeat (40) step(1, 1, 4'($urandom), 0);

    repeat (3) step(0, 1, 4'h0, 0);
    step(1, 1, 4'hB, 1);

    step(1, 0, 4'h6, 0);
    step(0, 1, 4'h0, 0);

    repeat (400) begin
      r = $urandom;
      step(r[0] | r[1], r[2], 4'(r[11:8]), r[7:0] == 0);
    end
    repeat (400) begin
      r = $urandom;
      step(r[0], r[1] | r[2], 4'(r[11:8]), r[7:0] == 0);
    end

    repeat (10) step(1, 0, 4'($urandom), 0);
    @(negedge clk);
    winc = 1'b1;
    wdata = 4'h3;
    #2 rst = 1'b0;
    model_reset();
    #1 chk_reset();
    @(negedge clk);
    winc = 1'b0;
    rst = 1'b1;
    repeat (3) step(1, 0, 4'($urandom), 0);
    repeat (4) step(0, 1, 4'h0, 0);

    #2 chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
